// File: rtl/afifo_pkg.sv
// Shared types and Gray-code helpers for the async FIFO.
// Used by the read-side pointer controller.
package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fwft_state_e;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_sync_ff.sv
// Multi-flop synchroniser for a Gray-coded pointer.
// Every stage clears on the asynchronous reset.
module afifo_sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // shift the foreign-domain value through the flop chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer, flags and output stage of an async FIFO.
// Supports standard and first-word-fall-through reads.
module rd_ptr_ctrl
  import afifo_pkg::*;
#(
  parameter int PTR_WIDTH   = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0
) (
  input  logic                  rd_clk_i,
  input  logic                  rstn_i,
  input  logic                  rd_en_i,
  input  logic [PTR_WIDTH:0]    wptr_gray_i,
  input  logic [PTR_WIDTH:0]    ae_thresh_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_rd_en_o,
  output logic [PTR_WIDTH-1:0]  mem_rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_empty_o,
  output logic                  rd_aempty_o,
  output logic [PTR_WIDTH:0]    rd_level_o,
  output logic                  rd_underflow_o,
  output logic [PTR_WIDTH:0]    rptr_gray_o
);

  localparam int PW1 = PTR_WIDTH + 1;

  logic [PW1-1:0] wsync_gray;
  logic [PW1-1:0] wsync_bin;
  logic [PW1-1:0] rptr_bin;
  logic [PW1-1:0] rptr_next;
  logic [PW1-1:0] rptr_gray;
  logic           mem_empty;
  logic           fetch;
  logic           uf_q;
  logic           lvl_add;

  afifo_sync_ff #(
    .WIDTH  (PW1),
    .STAGES (SYNC_STAGES)
  ) u_wsync (
    .clk  (rd_clk_i),
    .rstn (rstn_i),
    .d    (wptr_gray_i),
    .q    (wsync_gray)
  );

  assign wsync_bin = PW1'(gray2bin(32'(wsync_gray)));
  assign mem_empty = (rptr_bin == wsync_bin);
  assign rptr_next = rptr_bin + PW1'(fetch);

  // advance the read pointer and its Gray copy on each fetch
  always_ff @(posedge rd_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
    end else begin
      rptr_bin  <= rptr_next;
      rptr_gray <= PW1'(bin2gray(32'(rptr_next)));
    end
  end

  assign rptr_gray_o   = rptr_gray;
  assign mem_rd_en_o   = fetch;
  assign mem_rd_addr_o = rptr_bin[PTR_WIDTH-1:0];

  generate
    if (FWFT != 0) begin : g_fwft
      fwft_state_e           state;
      logic [DATA_WIDTH-1:0] hold_q;

      // fetch ahead when nothing is held, else on acknowledge
      always_comb begin
        fetch = 1'b0;
        unique case (state)
          IDLE:        fetch = ~mem_empty;
          FETCH, HOLD: fetch = rd_en_i & ~mem_empty;
          default:     fetch = 1'b0;
        endcase
      end

      // presented-word FSM with a holding register for stalls
      always_ff @(posedge rd_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          state  <= IDLE;
          hold_q <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              if (!mem_empty) state <= FETCH;
            end
            FETCH: begin
              if (rd_en_i) begin
                if (mem_empty) state <= IDLE;
              end else begin
                hold_q <= mem_rdata_i;
                state  <= HOLD;
              end
            end
            HOLD: begin
              if (rd_en_i) begin
                state <= mem_empty ? IDLE : FETCH;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end

      // select the live RAM word or the held copy
      always_comb begin
        rd_data_o = '0;
        unique case (state)
          FETCH:   rd_data_o = mem_rdata_i;
          HOLD:    rd_data_o = hold_q;
          default: rd_data_o = '0;
        endcase
      end

      assign rd_valid_o = (state != IDLE);
      assign rd_empty_o = ~rd_valid_o;
      assign lvl_add    = rd_valid_o;
    end else begin : g_std
      logic valid_q;

      assign fetch = rd_en_i & ~mem_empty;

      // data returns one cycle after the fetch
      always_ff @(posedge rd_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= fetch;
        end
      end

      assign rd_valid_o = valid_q;
      assign rd_data_o  = mem_rdata_i;
      assign rd_empty_o = mem_empty;
      assign lvl_add    = 1'b0;
    end
  endgenerate

  assign rd_level_o  = (wsync_bin - rptr_bin)
                     + PW1'(lvl_add);
  assign rd_aempty_o = (rd_level_o <= ae_thresh_i);

  // flag a read attempted while nothing is available
  always_ff @(posedge rd_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      uf_q <= 1'b0;
    end else begin
      uf_q <= rd_en_i & rd_empty_o;
    end
  end

  assign rd_underflow_o = uf_q;

endmodule
